// File: rtl/alu_mdu_control_if.sv
// EX-stage bus between the pipeline and the ALU control / multiply-divide sequencer.
interface alu_mdu_control_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 3
);
  logic               i_Valid;
  logic               i_Flush;
  logic [ALUOP_W-1:0] i_ALUOp;
  logic [2:0]         i_Funct3;
  logic [6:0]         i_Funct7;
  logic [XLEN-1:0]    i_A;
  logic [XLEN-1:0]    i_B;
  logic [3:0]         o_ALUControlLines;
  logic               o_IllegalOp;
  logic               o_Stall;
  logic               o_MduDone;
  logic [XLEN-1:0]    o_MduResult;

  modport master (
    output i_Valid, i_Flush, i_ALUOp, i_Funct3, i_Funct7, i_A, i_B,
    input  o_ALUControlLines, o_IllegalOp, o_Stall, o_MduDone, o_MduResult
  );
  modport slave (
    input  i_Valid, i_Flush, i_ALUOp, i_Funct3, i_Funct7, i_A, i_B,
    output o_ALUControlLines, o_IllegalOp, o_Stall, o_MduDone, o_MduResult
  );
endinterface

// File: rtl/alu_mdu_control.sv
// RV32 ALU control decode plus an iterative radix-2 multiply / restoring divide
// sequencer that stalls EX until the M-extension result is ready.
module alu_mdu_control #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int ALUOP_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_mdu_control_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [ALUOP_W-1:0] OP_IL    = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_B     = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_R     = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_I     = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_LUI   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_AUIPC = ALUOP_W'(5);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  typedef struct packed {
    logic [2:0] f3;
    logic       a_neg;
    logic       b_neg;
  } mdu_op_t;

  state_t              state;
  mdu_op_t             op_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     mcand;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]     result_q;
  logic                done_q;

  // ---------------- decode ----------------
  logic [3:0] alu_ctl;
  logic       bad;

  always_comb begin
    alu_ctl = ALU_ADD;
    bad     = 1'b0;
    case (bus.i_ALUOp)
      OP_IL:    alu_ctl = ALU_ADD;
      OP_B:     alu_ctl = ALU_SUB;
      OP_LUI:   alu_ctl = ALU_LUI;
      OP_AUIPC: alu_ctl = ALU_AUIPC;
      OP_R: begin
        if (bus.i_Funct7 == 7'h00) begin
          case (bus.i_Funct3)
            3'd0: alu_ctl = ALU_ADD;
            3'd1: alu_ctl = ALU_SLL;
            3'd2: alu_ctl = ALU_SLT;
            3'd3: alu_ctl = ALU_SLTU;
            3'd4: alu_ctl = ALU_XOR;
            3'd5: alu_ctl = ALU_SRL;
            3'd6: alu_ctl = ALU_OR;
            default: alu_ctl = ALU_AND;
          endcase
        end else if (bus.i_Funct7 == 7'h20 && bus.i_Funct3 == 3'd0) begin
          alu_ctl = ALU_SUB;
        end else if (bus.i_Funct7 == 7'h20 && bus.i_Funct3 == 3'd5) begin
          alu_ctl = ALU_SRA;
        end else if (bus.i_Funct7 == 7'h01) begin
          bad = (ENABLE_M == 0);
        end else begin
          bad = 1'b1;
        end
      end
      OP_I: begin
        case (bus.i_Funct3)
          3'd0: alu_ctl = ALU_ADD;
          3'd1: alu_ctl = ALU_SLL;
          3'd2: alu_ctl = ALU_SLT;
          3'd3: alu_ctl = ALU_SLTU;
          3'd4: alu_ctl = ALU_XOR;
          3'd5: begin
            if (bus.i_Funct7 == 7'h00)      alu_ctl = ALU_SRL;
            else if (bus.i_Funct7 == 7'h20) alu_ctl = ALU_SRA;
            else                            bad = 1'b1;
          end
          3'd6: alu_ctl = ALU_OR;
          default: alu_ctl = ALU_AND;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  assign bus.o_ALUControlLines = alu_ctl;
  assign bus.o_IllegalOp       = bus.i_Valid & bad;

  // ---------------- accept and operand preparation ----------------
  logic            m_op, accept, is_div, a_sgn, b_sgn, a_neg_in, b_neg_in, div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs;

  assign m_op   = (bus.i_ALUOp == OP_R) && (bus.i_Funct7 == 7'h01);
  // Reset also blocks accept so o_Stall reads low while reset is held.
  assign accept = (ENABLE_M != 0) && i_rst_n && (state == S_IDLE) &&
                  bus.i_Valid && m_op && !bus.i_Flush;

  assign is_div   = bus.i_Funct3[2];
  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM.
  assign a_sgn    = !(bus.i_Funct3 == 3'd3 || bus.i_Funct3 == 3'd5 || bus.i_Funct3 == 3'd7);
  assign b_sgn    = a_sgn && (bus.i_Funct3 != 3'd2);
  assign a_neg_in = a_sgn & bus.i_A[XLEN-1];
  assign b_neg_in = b_sgn & bus.i_B[XLEN-1];
  assign a_abs    = a_neg_in ? (~bus.i_A + 1'b1) : bus.i_A;
  assign b_abs    = b_neg_in ? (~bus.i_B + 1'b1) : bus.i_B;
  assign div0     = is_div && (bus.i_B == '0);
  assign ovf      = is_div && !bus.i_Funct3[0] &&
                    (bus.i_A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_B == '1);

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand};

  // Remainder stays below 2*divisor, so bit XLEN of the difference is a clean borrow.
  always_comb begin
    if (!op_q.f3[2])     acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                 acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  assign prod_s = (op_q.a_neg ^ op_q.b_neg) ? (~acc + 1'b1) : acc;
  assign quot_s = (op_q.a_neg ^ op_q.b_neg) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
  assign rem_s  = op_q.a_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q.f3)
      3'd0:       fix_res = prod_s[XLEN-1:0];
      3'd4, 3'd5: fix_res = quot_s;
      3'd6, 3'd7: fix_res = rem_s;
      default:    fix_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= '{f3: bus.i_Funct3, a_neg: a_neg_in, b_neg: b_neg_in};
            cnt  <= '0;
            if (div0) begin
              result_q <= bus.i_Funct3[1] ? bus.i_A : '1;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else if (ovf) begin
              result_q <= bus.i_Funct3[1] ? '0 : bus.i_A;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
              mcand <= is_div ? b_abs : a_abs;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.i_Flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.i_Flush) begin
            state <= S_IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;  // DONE: pipeline advances, no re-accept this edge
      endcase
    end
  end

  assign bus.o_Stall     = accept | (state == S_RUN) | (state == S_FIX);
  assign bus.o_MduDone   = done_q;
  assign bus.o_MduResult = result_q;
endmodule

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
- Next-generation ALU control for the RV32 core: the same ALUOp/Funct3/Funct7 decode to 4-bit ALU control lines, extended with RV32M support.
- Owns an iterative multiply/divide sequencer that stalls the pipeline while an M-extension op runs.
- Illegal encodings now give a deterministic default plus an error flag instead of X.
- Sits in EX, beside the ALU; the hazard unit consumes o_Stall.

Parameters:
XLEN, 32, operand/result width (even, >=8)
ENABLE_M, 1, 0 = M ops flagged illegal and sequencer never starts
ALUOP_W, 3, width of i_ALUOp

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_Valid  in  1  EX stage holds a valid instruction
i_Flush  in  1  abort any in-flight M op
i_ALUOp  in  ALUOP_W  main-control op class (I_L=0, B=1, R=2, I=3, LUI=4, AUIPC=5)
i_Funct3  in  3  instruction funct3
i_Funct7  in  7  instruction funct7
i_A  in  XLEN  rs1 operand
i_B  in  XLEN  rs2 operand
o_ALUControlLines  out  4  ALU operation (ALU_* encodings from ALU_CONTROL.vh)
o_IllegalOp  out  1  decode found an undefined combination
o_Stall  out  1  hold pipeline; M op not yet complete
o_MduDone  out  1  one-cycle strobe; o_MduResult valid
o_MduResult  out  XLEN  M-op result

Behaviour:
- Decode is combinational. Non-M mapping:
  - I_L: ADD. B: SUB. LUI: ALU_LUI. AUIPC: ALU_AUIPC.
  - R: funct7 0x00 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3 0..7; funct7 0x20 selects SUB (f3=0) or SRA (f3=5).
  - I: funct3 0..7 gives ADD/SLL/SLT/SLTU/XOR/OR/AND, ignoring funct7, except f3=5, where funct7 0x00 gives SRL and 0x20 gives SRA.
- Any other combination, including undefined ALUOp: o_ALUControlLines = ALU_ADD, o_IllegalOp = i_Valid. Never X.
- M op: ALUOp=R and funct7=0x01. funct3 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - o_ALUControlLines = ALU_ADD, don't-care.
  - With ENABLE_M=0 the op is illegal.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: i_Valid & M op & !i_Flush accepts the op.
  - Latches operands as absolute values plus sign flags, and latches funct3.
  - Clears the step counter; goes to RUN.
  - o_Stall is asserted combinationally in the accept cycle.
- Special cases on accept go directly to DONE next cycle:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
- RUN: one step per cycle for exactly XLEN cycles.
  - Multiply: radix-2 shift-add into a 2*XLEN unsigned product.
  - Divide: restoring, one quotient bit per step.
  - Counter width $clog2(XLEN)+1. Leaves for FIX when the counter reaches XLEN-1.
- FIX, one cycle: apply sign correction.
  - Product negated if operand signs differ; signed-ness per op (MULHSU: rs1 signed, rs2 unsigned).
  - Quotient negated if signs differ; remainder takes the dividend sign.
  - Select low/high word or quotient/remainder.
- DONE, one cycle: o_MduDone=1, o_Stall=0, then IDLE.
  - The pipeline advances on this edge, so the same instruction is not re-accepted: accept is blocked while in DONE.
- Latency: normal op, accept at cycle 0 and o_MduDone at cycle XLEN+2. Special case: o_MduDone at cycle 1.
- o_Stall = (IDLE & accept) | RUN | FIX.
- o_MduResult is registered; it holds its last value until the next FIX/special-case load.
- i_Flush in RUN or FIX: return to IDLE next edge, no o_MduDone, o_MduResult unchanged. i_Flush has priority over accept.
- i_Valid dropping mid-op is ignored; only i_Flush aborts.
- Reset (asynchronous, any state): FSM=IDLE, counter=0, o_MduResult=0, o_MduDone=0, o_Stall=0.
- Combinational outputs after reset track the inputs.

Test Plan:
- Decode sweep: all legal (ALUOp, f3, f7) triples give the table values; R f3=1 f7=0x20 and ALUOp=7 give ALU_ADD with o_IllegalOp=1 (i_Valid=1).
- MUL 7 x -3 (0xFFFFFFFD): o_Stall high cycles 0..33, o_MduDone at cycle 34, result 0xFFFFFFEB. MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU gives 2.
- DIV 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5, each done at cycle 1. DIV 0x80000000/-1 gives 0x80000000; REM gives 0.
- i_Flush at cycle 10 of MUL: no o_MduDone, o_Stall low next cycle, o_MduResult holds its previous value; a new DIV accepted afterwards completes correctly.
- i_rst_n low at cycle 5 of DIVU: all registered outputs 0 immediately; ENABLE_M=0 build: MUL flagged illegal, o_Stall never asserted.
